// File: rtl/cpu_irq_timer_if.sv
// CPU-side register bus for cpu_irq_timer: look-ahead access strobes in,
// registered read data and interrupt lines out.
interface cpu_irq_timer_if;
    logic       cs;
    logic [3:0] addr;
    logic       we;
    logic [7:0] di;
    logic       ready;
    logic [7:0] dout;
    logic       irq;
    logic       nmi;

    modport master (
        output cs, addr, we, di, ready,
        input  dout, irq, nmi
    );

    modport slave (
        input  cs, addr, we, di, ready,
        output dout, irq, nmi
    );
endinterface

// File: rtl/cpu_irq_timer.sv
// Memory-mapped interval timer with prescaler, interrupt status/mask
// registers, software interrupt and pulse-stretched NMI for the cpu4510 bus.
module cpu_irq_timer #(
    parameter int NMI_PULSE = 2
) (
    input  logic           clk,
    input  logic           reset,
    cpu_irq_timer_if.slave bus
);
    localparam logic [3:0] NMI_LOAD = 4'(NMI_PULSE);

    logic [15:0] latch_q, latch_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [7:0]  pre_q, pre_d;
    logic        run_q, run_d;
    logic        oneshot_q, oneshot_d;
    logic [1:0]  isr_q, isr_d;
    logic [1:0]  imr_q, imr_d;
    logic [3:0]  nmi_cnt_q, nmi_cnt_d;
    logic [7:0]  do_q, do_d;

    logic        access, wr, tick, underflow, irq;
    logic [7:0]  rdata;

    assign access    = bus.cs & bus.ready;
    assign wr        = access & bus.we;
    assign tick      = run_q && (pcnt_q == 8'd0);
    assign underflow = tick && (count_q == 16'd0);
    assign irq       = |(isr_q & imr_q);

    always_comb begin
        rdata = 8'h00;
        case (bus.addr)
            4'd0:    rdata = count_q[7:0];
            4'd1:    rdata = count_q[15:8];
            4'd2:    rdata = {6'b0, oneshot_q, run_q};
            4'd3:    rdata = {irq, 5'b0, isr_q};
            4'd4:    rdata = {6'b0, imr_q};
            4'd6:    rdata = pre_q;
            default: rdata = 8'h00;
        endcase
    end

    always_comb begin
        latch_d   = latch_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        pre_d     = pre_q;
        run_d     = run_q;
        oneshot_d = oneshot_q;
        isr_d     = isr_q;
        imr_d     = imr_q;
        nmi_cnt_d = (nmi_cnt_q != 4'd0) ? nmi_cnt_q - 4'd1 : 4'd0;
        do_d      = (access && !bus.we) ? rdata : do_q;

        // Timer first; register writes below override where they collide.
        if (run_q) begin
            if (pcnt_q != 8'd0) begin
                pcnt_d = pcnt_q - 8'd1;
            end else begin
                pcnt_d = pre_q;
                if (count_q != 16'd0) begin
                    count_d = count_q - 16'd1;
                end else begin
                    count_d = latch_q;
                    if (oneshot_q) run_d = 1'b0;
                end
            end
        end

        // ISR clear is applied before hardware sets so a same-edge set wins.
        if (wr) begin
            case (bus.addr)
                4'd0: latch_d[7:0]  = bus.di;
                4'd1: latch_d[15:8] = bus.di;
                4'd2: begin
                    run_d     = bus.di[0];
                    oneshot_d = bus.di[1];
                    if (bus.di[2]) begin
                        count_d = latch_q;
                        pcnt_d  = pre_q;
                    end
                end
                4'd3: isr_d = isr_q & ~bus.di[1:0];
                4'd4: imr_d = bus.di[1:0];
                4'd5: begin
                    if (bus.di[0]) isr_d[1] = 1'b1;
                    if (bus.di[1]) nmi_cnt_d = NMI_LOAD;
                end
                4'd6: pre_d = bus.di;
                default: ;
            endcase
        end

        if (underflow) isr_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_q   <= 16'hFFFF;
            count_q   <= 16'hFFFF;
            pcnt_q    <= 8'h00;
            pre_q     <= 8'h00;
            run_q     <= 1'b0;
            oneshot_q <= 1'b0;
            isr_q     <= 2'b00;
            imr_q     <= 2'b00;
            nmi_cnt_q <= 4'd0;
            do_q      <= 8'h00;
        end else begin
            latch_q   <= latch_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            pre_q     <= pre_d;
            run_q     <= run_d;
            oneshot_q <= oneshot_d;
            isr_q     <= isr_d;
            imr_q     <= imr_d;
            nmi_cnt_q <= nmi_cnt_d;
            do_q      <= do_d;
        end
    end

    assign bus.dout = do_q;
    assign bus.irq  = irq;
    assign bus.nmi  = (nmi_cnt_q != 4'd0);
endmodule

// File: tb/tb_cpu_irq_timer.sv
// Directed bench for cpu_irq_timer: each task drives one scenario and
// compares against hand-computed values.
module tb_cpu_irq_timer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    logic [7:0] rd;

    cpu_irq_timer_if bus ();

    cpu_irq_timer #(.NMI_PULSE(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1ns after a rising edge.
    task automatic bus_acc(input logic [3:0] a, input logic w, input logic [7:0] d,
                           input logic rdy, output logic [7:0] q);
        bus.cs = 1'b1; bus.addr = a; bus.we = w; bus.di = d; bus.ready = rdy;
        @(posedge clk); #1;
        q = bus.dout;
        bus.cs = 1'b0; bus.we = 1'b0; bus.ready = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus_acc(a, 1'b1, d, 1'b1, q);
    endtask

    task automatic rdreg(input logic [3:0] a, output logic [7:0] q);
        bus_acc(a, 1'b0, 8'h00, 1'b1, q);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(3);
        #2 reset = 1'b1;
        idle(1);
        vecs++; if (bus.dout !== 8'h00) begin errs++; $display("FAIL reset_do got %h exp 00", bus.dout); end
        vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
        vecs++; if (bus.nmi !== 1'b0) begin errs++; $display("FAIL reset_nmi got %b exp 0", bus.nmi); end
        rdreg(4'd0, rd);
        vecs++; if (rd !== 8'hFF) begin errs++; $display("FAIL reset_tlo got %h exp FF", rd); end
        rdreg(4'd1, rd);
        vecs++; if (rd !== 8'hFF) begin errs++; $display("FAIL reset_thi got %h exp FF", rd); end
        rdreg(4'd6, rd);
        vecs++; if (rd !== 8'h00) begin errs++; $display("FAIL reset_pre got %h exp 00", rd); end
    endtask

    task automatic test_periodic;
        wr(4'd0, 8'h03); wr(4'd1, 8'h00); wr(4'd6, 8'h01); wr(4'd4, 8'h01);
        wr(4'd2, 8'h05);                       // edge E0
        idle(7);                               // E0+7
        vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL per_early got %b exp 0", bus.irq); end
        idle(1);                               // E0+8
        vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL per_first got %b exp 1", bus.irq); end
        wr(4'd3, 8'h01);                       // E0+9 clears
        vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL per_clear got %b exp 0", bus.irq); end
        idle(6);                               // E0+15
        vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL per_early2 got %b exp 0", bus.irq); end
        idle(1);                               // E0+16
        vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL per_second got %b exp 1", bus.irq); end
        wr(4'd3, 8'h01);                       // E0+17
        idle(6);                               // E0+23
        wr(4'd3, 8'h01);                       // E0+24: clear on underflow edge
        vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL race_irq got %b exp 1", bus.irq); end
        rdreg(4'd3, rd);                       // E0+25
        vecs++; if (rd !== 8'h81) begin errs++; $display("FAIL race_isr got %h exp 81", rd); end
        wr(4'd2, 8'h00);
        wr(4'd3, 8'h03);
        vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL per_stop got %b exp 0", bus.irq); end
    endtask

    task automatic test_oneshot;
        wr(4'd0, 8'h02); wr(4'd1, 8'h00); wr(4'd6, 8'h00);
        wr(4'd2, 8'h07);                       // edge F0
        idle(2);
        vecs++; if (bus.irq !== 1'b0) begin errs++; $display("FAIL os_early got %b exp 0", bus.irq); end
        idle(1);                               // F3
        vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL os_tuf got %b exp 1", bus.irq); end
        rdreg(4'd2, rd);
        vecs++; if (rd !== 8'h02) begin errs++; $display("FAIL os_ctrl got %h exp 02", rd); end
        wr(4'd3, 8'h01);
        idle(6);
        rdreg(4'd0, rd);
        vecs++; if (rd !== 8'h02) begin errs++; $display("FAIL os_count got %h exp 02", rd); end
        rdreg(4'd3, rd);
        vecs++; if (rd !== 8'h00) begin errs++; $display("FAIL os_single got %h exp 00", rd); end
    endtask

    task automatic test_nmi;
        int highs;
        wr(4'd5, 8'h02);                       // G0
        highs = (bus.nmi === 1'b1) ? 1 : 0;
        wr(4'd5, 8'h02);                       // G1 extends
        for (int i = 0; i < 5; i++) begin
            if (bus.nmi === 1'b1) highs++;
            idle(1);
        end
        vecs++; if (highs !== 3) begin errs++; $display("FAIL nmi_len got %0d exp 3", highs); end
        vecs++; if (bus.nmi !== 1'b0) begin errs++; $display("FAIL nmi_end got %b exp 0", bus.nmi); end
        wr(4'd4, 8'h02);
        wr(4'd5, 8'h01);
        vecs++; if (bus.irq !== 1'b1) begin errs++; $display("FAIL swi_irq got %b exp 1", bus.irq); end
        rdreg(4'd3, rd);
        vecs++; if (rd !== 8'h82) begin errs++; $display("FAIL swi_isr got %h exp 82", rd); end
        rdreg(4'd5, rd);
        vecs++; if (rd !== 8'h00) begin errs++; $display("FAIL swcmd_rd got %h exp 00", rd); end
    endtask

    task automatic test_ready;
        logic [7:0] q;
        wr(4'd4, 8'h00);
        wr(4'd6, 8'h00); wr(4'd0, 8'h10); wr(4'd1, 8'h00);
        wr(4'd2, 8'h05);                       // H0
        rdreg(4'd0, rd);                       // H1
        vecs++; if (rd !== 8'h10) begin errs++; $display("FAIL rdy_cnt0 got %h exp 10", rd); end
        bus_acc(4'd4, 1'b1, 8'h03, 1'b0, q);   // H2 stalled write
        bus_acc(4'd4, 1'b0, 8'h00, 1'b0, q);   // H3 stalled read
        vecs++; if (q !== 8'h10) begin errs++; $display("FAIL rdy_do_hold got %h exp 10", q); end
        bus_acc(4'd3, 1'b1, 8'h03, 1'b0, q);   // H4 stalled clear
        rdreg(4'd0, rd);                       // H5
        vecs++; if (rd !== 8'h0C) begin errs++; $display("FAIL rdy_count got %h exp 0C", rd); end
        rdreg(4'd4, rd);
        vecs++; if (rd !== 8'h00) begin errs++; $display("FAIL rdy_imr got %h exp 00", rd); end
        rdreg(4'd3, rd);
        vecs++; if (rd !== 8'h02) begin errs++; $display("FAIL rdy_isr got %h exp 02", rd); end
        wr(4'd2, 8'h00);
    endtask

    task automatic test_midreset;
        wr(4'd6, 8'h05); wr(4'd2, 8'h05); wr(4'd4, 8'h03);
        wr(4'd5, 8'h03);
        rdreg(4'd6, rd);
        vecs++; if (rd !== 8'h05 || bus.nmi !== 1'b1 || bus.irq !== 1'b1) begin
            errs++; $display("FAIL mid_pre got %h/%b/%b exp 05/1/1", rd, bus.nmi, bus.irq);
        end
        #2 reset = 1'b0;
        #1;
        vecs++; if (bus.dout !== 8'h00 || bus.irq !== 1'b0 || bus.nmi !== 1'b0) begin
            errs++; $display("FAIL mid_async got %h/%b/%b exp 00/0/0", bus.dout, bus.irq, bus.nmi);
        end
        idle(2);
        #2 reset = 1'b1;
        idle(1);
        rdreg(4'd1, rd);
        vecs++; if (rd !== 8'hFF) begin errs++; $display("FAIL mid_thi got %h exp FF", rd); end
        rdreg(4'd6, rd);
        vecs++; if (rd !== 8'h00) begin errs++; $display("FAIL mid_pre0 got %h exp 00", rd); end
        rdreg(4'd2, rd);
        vecs++; if (rd !== 8'h00) begin errs++; $display("FAIL mid_ctrl got %h exp 00", rd); end
    endtask

    initial begin
        bus.cs = 1'b0; bus.addr = 4'd0; bus.we = 1'b0; bus.di = 8'h00; bus.ready = 1'b1;
        #1;
        test_reset();
        test_periodic();
        test_oneshot();
        test_nmi();
        test_ready();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cpu_irq_timer.md
# cpu_irq_timer

Memory-mapped interval timer and interrupt source on the cpu4510 data bus. It is the responder end of the CPU's `irq`/`nmi` inputs: it decodes CPU bus cycles using the look-ahead address, write strobe and data, the same way the synchronous `memory` block does. It returns read data one clock later and drives level `irq` and pulsed `nmi` back into the core. It replaces the ad-hoc I/O port used to poke interrupt lines during CPU bring-up.

## Interface
- `NMI_PULSE`, default 2: number of clocks `nmi` stays high per NMI request (1..15).
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset asserted).
- `cs` in 1: chip select, decoded externally from `address_next`.
- `addr` in 4: register index, `address_next[3:0]`.
- `we` in 1: CPU `write_next`.
- `di` in 8: CPU `data_o_next`.
- `ready` in 1: bus ready; when 0, no register access takes place.
- `do` out 8: registered read data, valid in the cycle after the access.
- `irq` out 1: level interrupt request, active-high.
- `nmi` out 1: NMI pulse, active-high.

## Operation
- An access occurs on an edge where `cs & ready` = 1.
- With `we`=1, the access writes register `addr` with `di`. With `we`=0, it loads `do` with the register contents.
- When no access occurs, `do` holds its value.
- Register map:
  - 0 TLO: write sets latch[7:0]; read returns count[7:0].
  - 1 THI: write sets latch[15:8]; read returns count[15:8].
  - 2 CTRL: bit0 RUN, bit1 ONESHOT (both R/W); bit2 LOAD is write-only (reads 0). Writing LOAD=1 copies latch to count and prescale reload to pcnt.
  - 3 ISR: bit0 TUF (timer underflow), bit1 SWI. Bit7 (read-only) = |(ISR[1:0] & IMR[1:0]). Writing 1 to a bit clears it.
  - 4 IMR: bits[1:0] are R/W; other bits read 0.
  - 5 SWCMD: writing bit0=1 sets ISR.SWI; writing bit1=1 starts an NMI pulse. Reads 0.
  - 6 PRE: 8-bit prescale reload, R/W.
  - 7..15: reads return 0x00; writes are ignored.
- Timer behaviour when RUN=1, every clock:
  - If pcnt≠0, pcnt decrements.
  - Otherwise pcnt reloads from PRE, and a tick occurs.
  - On a tick, if count≠0, count decrements.
  - On a tick with count=0: count reloads from latch, ISR.TUF is set, and if ONESHOT=1 then RUN is cleared.
  - Underflow period is (latch+1)·(PRE+1) clocks.
- RUN=0 freezes both count and pcnt.
- The timer runs regardless of `ready`.
- `irq` is a combinational output: `irq` = ISR bit7.
- NMI pulse: a 4-bit counter loads `NMI_PULSE` and `nmi` = (counter≠0). A new request while a pulse is active restarts the count; the pulse is extended, not stacked.
- Simultaneous events:
  - An ISR set by hardware and a write-1-clear of the same bit on the same edge: the set wins.
  - A CTRL write with LOAD on the same edge as an underflow: the LOAD value wins, TUF is still set, and the write's RUN bit wins over the ONESHOT clear.
  - A TLO/THI write during an underflow edge: the reload uses the old latch.
- Reset values: latch=count=0xFFFF, pcnt=PRE=0x00, CTRL=0, ISR=0, IMR=0, NMI counter=0, `do`=0x00, `irq`=0, `nmi`=0.
- Asserting reset mid-operation returns every register to these values immediately, independent of `clk`.

## Timing
- Read latency is 1 clock: the access on edge N presents data on `do` after edge N, matching `memory` timing with `address_next`.
- A write on edge N is visible to a read on edge N+1.
- For a count read, `do` shows count as it was before edge N.
- `irq` rises in the same cycle ISR/IMR change, i.e. after the setting edge, with no added register stage.
- `nmi` rises after the SWCMD write edge and stays high for exactly `NMI_PULSE` clocks.
- With latch=L, PRE=P, and LOAD+RUN written on edge 0: TUF sets on edge (L+1)(P+1).
- The `ready`=0 rule: when `cs`=1 but `ready`=0, no write commits, `do` holds, and there are no clear side effects.

## Test plan
- Reset: hold `reset`=0 mid-count, then release → `do`=00, `irq`=0, `nmi`=0; a read of TLO/THI returns FF/FF, and a read of PRE returns 00.
- Periodic: latch=0x0003, PRE=0x01, IMR=01, CTRL=0x05 → TUF/`irq` sets 8 clocks after the CTRL edge. Then write ISR=01 → `irq`=0. Next underflow arrives 8 clocks after the previous one.
- One-shot: latch=0x0002, PRE=0, CTRL=0x07 → exactly one TUF after 3 clocks; CTRL reads back 0x02; count frozen at 0x0002.
- Set-vs-clear race: arrange a write ISR=01 on the underflow edge → TUF stays 1 and `irq` stays high.
- NMI: `NMI_PULSE`=2, write SWCMD=02, then write it again 1 clock after the pulse starts → `nmi` high for 3 clocks total. Write SWCMD=01 with IMR=02 → `irq`=1 and ISR reads 0x82.
- Ready gating: `ready`=0 while writing IMR=03 → IMR still reads 00; `do` unchanged during the stalled read; timer keeps counting.
